// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready pipeline that widens an immediate field by zero/sign
// extension, sign-extend-and-shift, or sign-extend-and-negate.
module imm_extend_pipe #(
   parameter int IN_W  = 2,
   parameter int OUT_W = 8,
   parameter int SHIFT = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] xfer_cnt
);

   localparam logic [OUT_W-1:0] ONE_W = OUT_W'(1);

   logic             s1_valid;
   logic [IN_W-1:0]  s1_data;
   logic [1:0]       s1_mode;
   logic             s2_valid;
   logic [OUT_W-1:0] s2_result;
   logic [CNT_W-1:0] cnt_reg;

   logic             s1_en;
   logic             s2_en;
   logic [OUT_W-1:0] sx;
   logic [OUT_W-1:0] zx;
   logic [OUT_W-1:0] ext_next;

   assign s2_en     = !s2_valid || out_ready;
   assign s1_en     = !s1_valid || s2_en;
   assign in_ready  = s1_en;
   assign out_valid = s2_valid;
   assign out_data  = s2_result;
   assign xfer_cnt  = cnt_reg;

   // Low bits pass straight through; upper bits are either the sign bit or zero.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_ext
         if (gi < IN_W) begin : g_low
            assign sx[gi] = s1_data[gi];
            assign zx[gi] = s1_data[gi];
         end else begin : g_high
            assign sx[gi] = s1_data[IN_W-1];
            assign zx[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      ext_next = zx;
      case (s1_mode)
         2'b01:   ext_next = sx;
         2'b10:   ext_next = sx << SHIFT;
         2'b11:   ext_next = ~sx + ONE_W;
         default: ext_next = zx;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_mode   <= '0;
         s2_valid  <= 1'b0;
         s2_result <= '0;
         cnt_reg   <= '0;
      end else begin
         if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid)
               s2_result <= ext_next;
         end
         if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_data <= in_data;
               s1_mode <= in_mode;
            end
         end
         if (s2_valid && out_ready)
            cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and scoreboard checks of imm_extend_pipe in three parameterisations.
module tb_imm_extend_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A: defaults
   logic       reset_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [1:0] in_data_a, in_mode_a;
   logic [7:0] out_data_a, xfer_cnt_a;

   // Instance B: 4-bit counter
   logic       reset_bc, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [1:0] in_data_b, in_mode_b;
   logic [7:0] out_data_b;
   logic [3:0] xfer_cnt_b;

   // Instance C: 5 -> 16 bits, shift 2
   logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c;
   logic [4:0]  in_data_c;
   logic [1:0]  in_mode_c;
   logic [15:0] out_data_c;
   logic [7:0]  xfer_cnt_c;

   imm_extend_pipe dut_a (
      .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_data(in_data_a), .in_mode(in_mode_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_data(out_data_a), .xfer_cnt(xfer_cnt_a)
   );

   imm_extend_pipe #(.CNT_W(4)) dut_b (
      .clk(clk), .reset(reset_bc), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_data(in_data_b), .in_mode(in_mode_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_data(out_data_b), .xfer_cnt(xfer_cnt_b)
   );

   imm_extend_pipe #(.IN_W(5), .OUT_W(16), .SHIFT(2)) dut_c (
      .clk(clk), .reset(reset_bc), .in_valid(in_valid_c), .in_ready(in_ready_c),
      .in_data(in_data_c), .in_mode(in_mode_c), .out_valid(out_valid_c),
      .out_ready(out_ready_c), .out_data(out_data_c), .xfer_cnt(xfer_cnt_c)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Four back-to-back items into A with out_ready high; item i sits in bits [i].
   task automatic a_stream4(input string tag, input logic [7:0] d, input logic [7:0] m,
                            input logic [31:0] e);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            check({tag, "_v"}, 32'(out_valid_a), 32'd1);
            check(tag, 32'(out_data_a), 32'(e[8*(k-2) +: 8]));
         end
         if (k < 4) begin
            in_valid_a = 1'b1;
            in_data_a  = d[2*k +: 2];
            in_mode_a  = m[2*k +: 2];
         end else begin
            in_valid_a = 1'b0;
         end
      end
   endtask

   // Reference built from signed integer arithmetic.
   function automatic logic [15:0] model_c(input logic [4:0] d, input logic [1:0] m);
      int s;
      int r;
      s = d[4] ? int'(d) - 32 : int'(d);
      case (m)
         2'd0:    r = int'(d);
         2'd1:    r = s;
         2'd2:    r = s * 4;
         default: r = -s;
      endcase
      return r[15:0];
   endfunction

   logic [15:0] sb[$];
   int pushed = 0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_a = 1'b1; reset_bc = 1'b1;
      in_valid_a = 1'b0; in_data_a = '0; in_mode_a = '0; out_ready_a = 1'b1;
      in_valid_b = 1'b0; in_data_b = '0; in_mode_b = '0; out_ready_b = 1'b1;
      in_valid_c = 1'b0; in_data_c = '0; in_mode_c = '0; out_ready_c = 1'b1;
      repeat (2) @(negedge clk);
      reset_a = 1'b0; reset_bc = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_out_data",  32'(out_data_a),  32'd0);
      check("rst_xfer_cnt",  32'(xfer_cnt_a),  32'd0);
      check("rst_in_ready",  32'(in_ready_a),  32'd1);
      check("rst_c_out_valid", 32'(out_valid_c), 32'd0);

      // Test 1: sign and zero extension
      a_stream4("t1_sext", 8'b11_10_01_00, 8'b01_01_01_01, {8'hFF, 8'hFE, 8'h01, 8'h00});
      a_stream4("t1_zext", 8'b11_10_01_00, 8'b00_00_00_00, {8'h03, 8'h02, 8'h01, 8'h00});
      // Test 2: shift and negate
      a_stream4("t2_a", 8'b01_10_01_10, 8'b11_11_10_10, {8'hFF, 8'h02, 8'h02, 8'hFC});
      a_stream4("t2_b", 8'b10_11_11_00, 8'b00_01_10_11, {8'h02, 8'hFF, 8'hFE, 8'h00});
      @(negedge clk);
      check("t2_xfer_cnt", 32'(xfer_cnt_a), 32'd16);

      // Test 3: backpressure absorbs two items, then drains in order
      out_ready_a = 1'b0;
      in_valid_a = 1'b1; in_data_a = 2'd1; in_mode_a = 2'b00;
      #1 check("t3_rdy0", 32'(in_ready_a), 32'd1);
      @(negedge clk);
      in_data_a = 2'd2;
      #1 check("t3_rdy1", 32'(in_ready_a), 32'd1);
      @(negedge clk);
      in_data_a = 2'd3;
      #1 check("t3_rdy2", 32'(in_ready_a), 32'd0);
      check("t3_vld2", 32'(out_valid_a), 32'd1);
      check("t3_hold2", 32'(out_data_a), 32'h01);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1 check("t3_rdy_stall", 32'(in_ready_a), 32'd0);
         check("t3_hold", 32'(out_data_a), 32'h01);
      end
      @(negedge clk);
      out_ready_a = 1'b1;
      #1 check("t3_rdy_release", 32'(in_ready_a), 32'd1);
      check("t3_out0", 32'(out_data_a), 32'h01);
      @(negedge clk);
      check("t3_out1", 32'(out_data_a), 32'h02);
      in_data_a = 2'b10; in_mode_a = 2'b01;
      @(negedge clk);
      check("t3_out2", 32'(out_data_a), 32'h03);
      in_data_a = 2'b10; in_mode_a = 2'b10;
      @(negedge clk);
      check("t3_out3", 32'(out_data_a), 32'hFE);
      in_valid_a = 1'b0;
      @(negedge clk);
      check("t3_out4", 32'(out_data_a), 32'hFC);
      @(negedge clk);
      check("t3_empty", 32'(out_valid_a), 32'd0);
      check("t3_xfer_cnt", 32'(xfer_cnt_a), 32'd21);

      // Test 4: reset with both stages full, plus an input offered during reset
      out_ready_a = 1'b0;
      in_valid_a = 1'b1; in_data_a = 2'b10; in_mode_a = 2'b01;
      @(negedge clk);
      in_mode_a = 2'b10;
      @(negedge clk);
      in_data_a = 2'b01; in_mode_a = 2'b00;
      #1 check("t4_full", 32'(in_ready_a), 32'd0);
      @(negedge clk);
      reset_a = 1'b1;
      @(negedge clk);
      check("t4_out_valid", 32'(out_valid_a), 32'd0);
      check("t4_out_data",  32'(out_data_a),  32'd0);
      check("t4_xfer_cnt",  32'(xfer_cnt_a),  32'd0);
      #1 check("t4_in_ready", 32'(in_ready_a), 32'd1);
      reset_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t4_no_stale", 32'(out_valid_a), 32'd0);
      end

      // Test 5: 4-bit counter wraps after 16 transfers
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k >= 2 && k <= 18)
            check("t5_data", 32'(out_data_b), 32'((k - 2) % 4));
         if (k == 18) check("t5_cnt16", 32'(xfer_cnt_b), 32'd0);
         if (k == 19) check("t5_cnt17", 32'(xfer_cnt_b), 32'd1);
         if (k < 17) begin
            in_valid_b = 1'b1; in_data_b = 2'(k); in_mode_b = 2'b00;
         end else begin
            in_valid_b = 1'b0;
         end
      end

      // Test 6: wide instance, directed then randomised handshakes
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         case (k)
            2: check("t6_sext",  32'(out_data_c), 32'hFFF0);
            3: check("t6_shift", 32'(out_data_c), 32'hFFC0);
            4: check("t6_neg",   32'(out_data_c), 32'h0010);
            5: check("t6_zext",  32'(out_data_c), 32'h0010);
            default: ;
         endcase
         in_valid_c = (k < 4);
         in_data_c  = 5'b10000;
         case (k)
            0: in_mode_c = 2'b01;
            1: in_mode_c = 2'b10;
            2: in_mode_c = 2'b11;
            default: in_mode_c = 2'b00;
         endcase
      end
      @(negedge clk);
      check("t6_cnt4", 32'(xfer_cnt_c), 32'd4);
      pushed = 4;

      for (int k = 0; k < 420; k++) begin
         @(negedge clk);
         if (k < 400) begin
            in_valid_c  = ($urandom_range(0, 1) == 1);
            in_data_c   = 5'($urandom);
            in_mode_c   = 2'($urandom);
            out_ready_c = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid_c  = 1'b0;
            out_ready_c = 1'b1;
         end
         #1;
         if (out_valid_c && out_ready_c) begin
            check("t6_sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0)
               check("t6_sb_data", 32'(out_data_c), 32'(sb.pop_front()));
         end
         if (in_valid_c && in_ready_c) begin
            sb.push_back(model_c(in_data_c, in_mode_c));
            pushed++;
         end
      end
      @(negedge clk);
      check("t6_drained", 32'(sb.size()), 32'd0);
      check("t6_cnt_total", 32'(xfer_cnt_c), 32'(pushed[7:0]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
